// File: rtl/sram_pkg.sv
// Shared definitions for the byte-lane synchronous SRAM.
// Latency: none (constants and a constant function only).
// Backpressure: not applicable.
// Contents: read-latency limits and the lane-count helper.
package sram_pkg;

   localparam int unsigned RD_LAT_MIN = 1;
   localparam int unsigned RD_LAT_MAX = 4;

   // Number of independently writable lanes in one word.
   function automatic int unsigned nlanes(input int unsigned data_w,
                                          input int unsigned lane_w);
      return data_w / lane_w;
   endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Show-ahead response FIFO with empty bypass: a push into an empty FIFO is
// visible on the output in the same cycle.
// Latency: 0 cycles when empty (bypass), otherwise head-of-line.
// Backpressure: holds the output while out_rdy_i=0; the caller guarantees
//   no push when full.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   push_i, push_dat_i  write side
//   out_vld_o/out_rdy_i/out_dat_o  read side handshake
//   cnt_o               number of stored (non-bypassed) entries
module sram_rsp_fifo #(
   parameter  int unsigned W     = 33,
   parameter  int unsigned DEPTH = 3,
   localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [W-1:0]  push_dat_i,
   output logic          out_vld_o,
   input  logic          out_rdy_i,
   output logic [W-1:0]  out_dat_o,
   output logic [CW-1:0] cnt_o
);

   logic [W-1:0]  mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          empty, pop, store, deq;

   always_comb begin
      empty     = (cnt_q == '0);
      out_vld_o = !empty || push_i;
      out_dat_o = empty ? push_dat_i : mem_q[rd_ptr_q];
      pop       = out_vld_o && out_rdy_i;
      // A push that is consumed straight through the bypass is never stored.
      store     = push_i && !(empty && pop);
      deq       = pop && !empty;
      cnt_d     = cnt_q + CW'(store) - CW'(deq);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      // Pointers wrap explicitly because DEPTH need not be a power of two.
      if (store) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      if (deq)   rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         cnt_q    <= cnt_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (store) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/sram_sync_be.sv
// Synchronous single-port SRAM with per-lane write enables and in-order reads.
// Latency: read response RD_LAT cycles after acceptance (earliest); writes
//   take effect at the accepting edge.
// Backpressure: req_ready is a registered credit check (outstanding reads <
//   RSP_DEPTH); reads and writes stall together so order is preserved.
// Ports:
//   CLK, RST                          clock, synchronous active-high reset
//   req_valid/req_ready, req_we, req_addr, req_be, req_wdata   request
//   rsp_valid/rsp_ready, rsp_rdata, rsp_err                    read response
module sram_sync_be
   import sram_pkg::*;
#(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned LANE_W    = 8,
   parameter int unsigned DEPTH     = 32,
   parameter int unsigned ADDR_W    = 5,
   parameter int unsigned RD_LAT    = 2,
   parameter int unsigned RSP_DEPTH = RD_LAT + 1
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_we,
   input  logic [ADDR_W-1:0]         req_addr,
   input  logic [DATA_W/LANE_W-1:0]  req_be,
   input  logic [DATA_W-1:0]         req_wdata,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      rsp_err
);

   localparam int unsigned NL = nlanes(DATA_W, LANE_W);
   localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
   localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

   typedef struct packed {
      logic              err;
      logic [DATA_W-1:0] rdata;
   } rsp_t;

   if (DATA_W % LANE_W != 0) begin : g_chk_lane
      $error("DATA_W must be a multiple of LANE_W");
   end
   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_chk_lat
      $error("RD_LAT out of range 1..4");
   end
   if ((64'd1 << ADDR_W) < 64'(DEPTH)) begin : g_chk_addr
      $error("ADDR_W too narrow for DEPTH");
   end

   logic [DATA_W-1:0] mem_q [DEPTH];
   rsp_t              pipe_dat_q [RD_LAT];
   logic [RD_LAT-1:0] pipe_vld_q;
   rsp_t              pipe0_d;
   logic [CW-1:0]     crd_q, crd_d, fifo_cnt;
   logic              rdy_q;
   logic              acc, rd_acc, wr_en, in_range, pop;
   rsp_t              out_dat;

   always_comb begin
      in_range = ({1'b0, req_addr} < DEPTH_X);
      // Requests presented during reset are not taken.
      acc      = req_valid && rdy_q && !RST;
      rd_acc   = acc && !req_we;
      wr_en    = acc && req_we && in_range;
      pop      = rsp_valid && rsp_ready;
      pipe0_d  = '0;
      pipe0_d.err = !in_range;
      if (in_range) pipe0_d.rdata = mem_q[req_addr];
      crd_d    = crd_q + CW'(rd_acc) - CW'(pop);
   end

   // Storage is deliberately not reset.
   always_ff @(posedge CLK) begin
      if (wr_en) begin
         for (int i = 0; i < NL; i++) begin
            if (req_be[i]) mem_q[req_addr][i*LANE_W +: LANE_W] <= req_wdata[i*LANE_W +: LANE_W];
         end
      end
   end

   // Stage 0 samples the array at the accepting edge; RD_LAT-1 more follow.
   always_ff @(posedge CLK) begin
      if (RST) begin
         pipe_vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) pipe_dat_q[i] <= '0;
      end else begin
         pipe_vld_q[0] <= rd_acc;
         pipe_dat_q[0] <= pipe0_d;
         for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_dat_q[i] <= pipe_dat_q[i-1];
         end
      end
   end

   // Credit counter: ready is computed from the next count so it stays a
   // pure register output with no path from rsp_ready.
   always_ff @(posedge CLK) begin
      if (RST) begin
         crd_q <= '0;
         rdy_q <= 1'b1;
      end else begin
         crd_q <= crd_d;
         rdy_q <= (crd_d < CW'(RSP_DEPTH));
      end
   end

   sram_rsp_fifo #(
      .W     ($bits(rsp_t)),
      .DEPTH (RSP_DEPTH)
   ) u_rsp_fifo (
      .clk_i      (CLK),
      .rst_i      (RST),
      .push_i     (pipe_vld_q[RD_LAT-1]),
      .push_dat_i (pipe_dat_q[RD_LAT-1]),
      .out_vld_o  (rsp_valid),
      .out_rdy_i  (rsp_ready),
      .out_dat_o  (out_dat),
      .cnt_o      (fifo_cnt)
   );

   // Every stored response holds a credit, so the buffer cannot overflow.
   a_fifo_within_credit: assert property (@(posedge CLK) disable iff (RST) fifo_cnt <= crd_q);

   assign req_ready = rdy_q;
   assign rsp_err   = out_dat.err;
   assign rsp_rdata = out_dat.rdata;

endmodule

// File: tb/tb_sram_sync_be.sv
// Directed bench for sram_sync_be (DEPTH=20, RD_LAT=2, RSP_DEPTH=3).
// Stimulus pushes expected read responses into a queue; a monitor pops and
// compares on every response transfer.
module tb_sram_sync_be;

   logic        CLK = 1'b0;
   logic        RST;
   logic        req_valid, req_ready, req_we;
   logic [4:0]  req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;

   typedef struct {
      logic        err;
      logic [31:0] dat;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] exp_mem [20];
   int          n_tests = 0;
   int          n_fail  = 0;

   always #5 CLK = ~CLK;

   sram_sync_be #(
      .DATA_W (32), .LANE_W (8), .DEPTH (20), .ADDR_W (5), .RD_LAT (2)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_be    (req_be),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_err   (rsp_err)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   task automatic timeout(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s: got timeout required handshake", nm);
   endtask

   // Monitor: one comparison per response transfer.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (!RST && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_rsp: got err=%b data=%h required no response", rsp_err, rsp_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_err", 64'(rsp_err), 64'(e.err));
               chk("rsp_rdata", 64'(rsp_rdata), 64'(e.dat));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish required finish");
      $fatal(1, "watchdog");
   end

   task automatic wait_rdy(input string nm, output bit ok);
      int n = 0;
      @(negedge CLK);
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge CLK);
         n++;
      end
      ok = (req_ready === 1'b1);
      if (!ok) timeout(nm);
   endtask

   task automatic wr(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
      bit ok;
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_be = be; req_wdata = d;
      wait_rdy("wr_accept", ok);
      if (ok && a < 20) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) exp_mem[a][i*8 +: 8] = d[i*8 +: 8];
      end
      @(posedge CLK); #1;
      req_valid = 1'b0;
   endtask

   task automatic rd(input logic [4:0] a, input logic e_err, input logic [31:0] e_dat,
                     input bit push, input bit must_rdy);
      bit ok;
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_be = 4'h0; req_wdata = '0;
      if (must_rdy) begin
         @(negedge CLK);
         chk("req_ready_now", 64'(req_ready), 64'd1);
         ok = (req_ready === 1'b1);
         if (!ok) wait_rdy("rd_accept", ok);
      end else begin
         wait_rdy("rd_accept", ok);
      end
      if (ok && push) exp_q.push_back('{err: e_err, dat: e_dat});
      @(posedge CLK); #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge CLK); #1;
         n++;
      end
      if (exp_q.size() != 0) timeout("drain");
      @(posedge CLK); #1;
   endtask

   initial begin
      int run;
      RST = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_be = '0; req_wdata = '0; rsp_ready = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;

      // Reset state.
      @(negedge CLK);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_rsp_err", 64'(rsp_err), 64'd0);
      chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      @(posedge CLK); #1;

      // Known contents for every in-range word.
      for (int k = 0; k < 20; k++) wr(5'(k), 4'hF, 32'hA500_0000 | (32'(k) * 32'h0001_0101));

      // 1: full write then read, exact latency.
      wr(5'd3, 4'hF, 32'hDEAD_BEEF);
      rd(5'd3, 1'b0, 32'hDEAD_BEEF, 1, 1);
      @(negedge CLK);
      chk("lat_t1_rsp_valid", 64'(rsp_valid), 64'd0);
      @(negedge CLK);
      chk("lat_t2_rsp_valid", 64'(rsp_valid), 64'd1);
      @(posedge CLK); #1;
      drain();

      // 2: partial-lane write merge.
      wr(5'd5, 4'hF, 32'h1122_3344);
      wr(5'd5, 4'b0101, 32'hAABB_CCDD);
      rd(5'd5, 1'b0, 32'h11BB_33DD, 1, 1);
      drain();

      // 3: backpressure, exactly three credits.
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) rd(5'(k), 1'b0, exp_mem[k], 1, 1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'd3;
      repeat (3) begin
         @(negedge CLK);
         chk("bp_req_ready", 64'(req_ready), 64'd0);
         chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
         chk("bp_rsp_hold", 64'(rsp_rdata), 64'(exp_mem[0]));
         @(posedge CLK); #1;
      end
      rsp_ready = 1'b1;
      rd(5'd3, 1'b0, exp_mem[3], 1, 0);
      rd(5'd4, 1'b0, exp_mem[4], 1, 0);
      drain();

      // 4: out-of-range read in order; out-of-range write dropped.
      rd(5'd1, 1'b0, exp_mem[1], 1, 1);
      rd(5'd25, 1'b1, 32'h0, 1, 1);
      rd(5'd2, 1'b0, exp_mem[2], 1, 1);
      drain();
      wr(5'd25, 4'hF, 32'hFFFF_FFFF);
      for (int k = 0; k < 20; k++) rd(5'(k), 1'b0, exp_mem[k], 1, 1);
      drain();

      // 5: sustained throughput, then read-after-write.
      fork
         begin
            for (int k = 0; k < 16; k++) rd(5'(k), 1'b0, exp_mem[k], 1, 1);
         end
         begin
            int n = 0;
            @(negedge CLK);
            while (rsp_valid !== 1'b1 && n < 10) begin
               @(negedge CLK);
               n++;
            end
            run = 0;
            while (rsp_valid === 1'b1 && run < 40) begin
               run++;
               @(negedge CLK);
            end
            chk("stream_valid_run", 64'(run), 64'd16);
         end
      join
      drain();
      wr(5'd7, 4'hF, 32'h0000_0005);
      rd(5'd7, 1'b0, 32'h0000_0005, 1, 1);
      drain();

      // 6: reset with reads in flight.
      rsp_ready = 1'b0;
      rd(5'd0, 1'b0, 32'h0, 0, 1);
      rd(5'd1, 1'b0, 32'h0, 0, 1);
      RST = 1'b1;
      @(posedge CLK); #1;
      RST = 1'b0;
      rsp_ready = 1'b1;
      repeat (4) begin
         @(negedge CLK);
         chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
         chk("post_rst_req_ready", 64'(req_ready), 64'd1);
         @(posedge CLK); #1;
      end
      rd(5'd7, 1'b0, 32'h0000_0005, 1, 1);
      drain();
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
